// File: rtl/vend_txn_ctrl.sv
// Transaction sequencer for the two-drink vending machine: coin credit,
// purchase validation against price/stock, dispense hold and change-return hold.
module vend_txn_ctrl #(
    parameter int unsigned PRICE_A    = 3,
    parameter int unsigned PRICE_B    = 5,
    parameter int unsigned STOCK_INIT = 10,
    parameter int unsigned HOLD_CYC   = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       op_start,
    input  logic       coin_in,
    input  logic [1:0] coin_type,
    input  logic [1:0] drink_type,
    input  logic       go,
    input  logic       cancel_flag,
    output logic       open,
    output logic [4:0] credit,
    output logic [4:0] charge_val,
    output logic       charge_ind,
    output logic [1:0] drinktk_ind,
    output logic       can_take,
    output logic       no_money,
    output logic       no_num,
    output logic       over_flow,
    output logic [4:0] num1,
    output logic [4:0] num2,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_IDLE     = 3'd1,
        S_CREDIT   = 3'd2,
        S_DISPENSE = 3'd3,
        S_CHANGE   = 3'd4
    } state_t;

    localparam int unsigned CW        = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [4:0] PRICE_A_V  = 5'(PRICE_A);
    localparam logic [4:0] PRICE_B_V  = 5'(PRICE_B);
    localparam logic [4:0] STOCK_V    = 5'(STOCK_INIT);

    state_t        state_q, state_d;
    logic [4:0]    credit_d;
    logic [4:0]    change_q, change_d;
    logic [CW-1:0] hold_q, hold_d;
    logic [4:0]    num1_d, num2_d;
    logic [1:0]    drink_d;
    logic          no_money_d, no_num_d, over_flow_d;
    logic [5:0]    coin_val;
    logic [5:0]    credit_sum;
    logic          sel_valid;
    logic [4:0]    sel_stock;
    logic [4:0]    sel_price;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_OFF;
            credit      <= '0;
            change_q    <= '0;
            hold_q      <= '0;
            num1        <= STOCK_V;
            num2        <= STOCK_V;
            drinktk_ind <= '0;
            no_money    <= 1'b0;
            no_num      <= 1'b0;
            over_flow   <= 1'b0;
            open        <= 1'b0;
            can_take    <= 1'b0;
            charge_ind  <= 1'b0;
            charge_val  <= '0;
        end else begin
            state_q     <= state_d;
            credit      <= credit_d;
            change_q    <= change_d;
            hold_q      <= hold_d;
            num1        <= num1_d;
            num2        <= num2_d;
            drinktk_ind <= drink_d;
            no_money    <= no_money_d;
            no_num      <= no_num_d;
            over_flow   <= over_flow_d;
            open        <= (state_d != S_OFF);
            can_take    <= (state_d == S_DISPENSE);
            charge_ind  <= (state_d == S_CHANGE);
            charge_val  <= (state_d == S_CHANGE) ? change_d : '0;
        end
    end

    assign state = state_q;

    always_comb begin
        state_d     = state_q;
        credit_d    = credit;
        change_d    = change_q;
        hold_d      = '0;
        num1_d      = num1;
        num2_d      = num2;
        drink_d     = drinktk_ind;
        no_money_d  = no_money;
        no_num_d    = no_num;
        over_flow_d = over_flow;

        case (coin_type)
            2'b00:   coin_val = 6'd1;
            2'b01:   coin_val = 6'd5;
            2'b10:   coin_val = 6'd10;
            default: coin_val = 6'd0;
        endcase
        credit_sum = {1'b0, credit} + coin_val;
        sel_valid  = (drink_type == 2'b01) || (drink_type == 2'b10);
        sel_stock  = (drink_type == 2'b01) ? num1 : num2;
        sel_price  = (drink_type == 2'b01) ? PRICE_A_V : PRICE_B_V;

        case (state_q)
            S_OFF: begin
                if (op_start) state_d = S_IDLE;
            end
            S_IDLE, S_CREDIT: begin
                // Power-off with credit outstanding is handled as a refund;
                // OFF is reached once the change phase finishes.
                if (!op_start && state_q == S_IDLE) begin
                    state_d = S_OFF;
                end else if (cancel_flag || !op_start) begin
                    if (credit != 5'd0) begin
                        change_d    = credit;
                        credit_d    = '0;
                        no_money_d  = 1'b0;
                        no_num_d    = 1'b0;
                        over_flow_d = 1'b0;
                        state_d     = S_CHANGE;
                    end
                end else if (go) begin
                    if (sel_valid) begin
                        if (sel_stock == 5'd0) begin
                            no_num_d = 1'b1;
                        end else if (credit < sel_price) begin
                            no_money_d = 1'b1;
                        end else begin
                            change_d = credit - sel_price;
                            credit_d = '0;
                            if (drink_type == 2'b01) num1_d = num1 - 5'd1;
                            else                     num2_d = num2 - 5'd1;
                            drink_d     = drink_type;
                            no_money_d  = 1'b0;
                            no_num_d    = 1'b0;
                            over_flow_d = 1'b0;
                            state_d     = S_DISPENSE;
                        end
                    end
                end else if (coin_in && coin_type != 2'b11) begin
                    if (credit_sum <= 6'd31) begin
                        credit_d    = credit_sum[4:0];
                        no_money_d  = 1'b0;
                        no_num_d    = 1'b0;
                        over_flow_d = 1'b0;
                        state_d     = S_CREDIT;
                    end else begin
                        over_flow_d = 1'b1;
                    end
                end
            end
            S_DISPENSE: begin
                if (hold_q == HOLD_LAST) begin
                    drink_d = '0;
                    if (change_q != 5'd0) state_d = S_CHANGE;
                    else                  state_d = op_start ? S_IDLE : S_OFF;
                end else begin
                    hold_d = hold_q + CW'(1);
                end
            end
            S_CHANGE: begin
                if (hold_q == HOLD_LAST) begin
                    change_d = '0;
                    state_d  = op_start ? S_IDLE : S_OFF;
                end else begin
                    hold_d = hold_q + CW'(1);
                end
            end
            default: state_d = S_OFF;
        endcase
    end

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Self-checking bench for vend_txn_ctrl: directed scenarios plus randomized
// transactions checked against a transaction-level model of the vending rules.
module tb_vend_txn_ctrl;

    localparam int PA   = 3;
    localparam int PB   = 5;
    localparam int SI   = 10;
    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       reset, op_start, coin_in, go, cancel_flag;
    logic [1:0] coin_type, drink_type;
    logic       open, charge_ind, can_take, no_money, no_num, over_flow;
    logic [4:0] credit, charge_val, num1, num2;
    logic [1:0] drinktk_ind;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    // Model state
    int m_credit;
    int m_stock[1:2];
    bit m_no_money, m_no_num, m_over, m_op;
    logic [1:0] first_dk;
    logic [4:0] first_cv;

    vend_txn_ctrl #(.PRICE_A(PA), .PRICE_B(PB), .STOCK_INIT(SI), .HOLD_CYC(HOLD)) dut (
        .clk(clk), .reset(reset), .op_start(op_start), .coin_in(coin_in),
        .coin_type(coin_type), .drink_type(drink_type), .go(go), .cancel_flag(cancel_flag),
        .open(open), .credit(credit), .charge_val(charge_val), .charge_ind(charge_ind),
        .drinktk_ind(drinktk_ind), .can_take(can_take), .no_money(no_money), .no_num(no_num),
        .over_flow(over_flow), .num1(num1), .num2(num2), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    function automatic logic [30:0] obs();
        return {open, state, credit, charge_val, charge_ind, drinktk_ind, can_take,
                no_money, no_num, over_flow, num1, num2};
    endfunction

    function automatic logic [30:0] expv(input int st, input int cv, input int dk);
        return {(st != 0), 3'(st), 5'(m_credit), 5'(cv), (st == 4), 2'(dk), (st == 3),
                m_no_money, m_no_num, m_over, 5'(m_stock[1]), 5'(m_stock[2])};
    endfunction

    function automatic int idle_st();
        if (!m_op) return 0;
        return (m_credit > 0) ? 2 : 1;
    endfunction

    function automatic void model_reset();
        m_credit = 0; m_stock[1] = SI; m_stock[2] = SI;
        m_no_money = 0; m_no_num = 0; m_over = 0;
    endfunction

    // outcome: 0 = no phase, 1 = dispense (then change if amt>0), 2 = refund
    task automatic model_step(input bit c, input logic [1:0] ct, input bit g,
                              input logic [1:0] dt, input bit cx,
                              output int outcome, output int amt);
        int price, val;
        outcome = 0; amt = 0;
        if (cx || (!m_op && m_credit > 0)) begin
            if (m_credit > 0) begin
                amt = m_credit; m_credit = 0;
                m_no_money = 0; m_no_num = 0; m_over = 0;
                outcome = 2;
            end
        end else if (g) begin
            if (dt == 2'b01 || dt == 2'b10) begin
                price = (dt == 2'b01) ? PA : PB;
                if (m_stock[int'(dt)] == 0) m_no_num = 1;
                else if (m_credit < price) m_no_money = 1;
                else begin
                    amt = m_credit - price; m_credit = 0;
                    m_stock[int'(dt)] -= 1;
                    m_no_money = 0; m_no_num = 0; m_over = 0;
                    outcome = 1;
                end
            end
        end else if (c && ct != 2'b11) begin
            val = (ct == 2'b00) ? 1 : (ct == 2'b01) ? 5 : 10;
            if (m_credit + val <= 31) begin
                m_credit += val;
                m_no_money = 0; m_no_num = 0; m_over = 0;
            end else m_over = 1;
        end
    endtask

    // Drives one strobe cycle and follows any resulting dispense/change phase.
    task automatic exec_txn(input string name, input bit c, input logic [1:0] ct,
                            input bit g, input logic [1:0] dt, input bit cx);
        int outcome, amt;
        coin_in = c; coin_type = ct; go = g; drink_type = dt; cancel_flag = cx;
        op_start = m_op;
        @(negedge clk);
        coin_in = 0; go = 0; cancel_flag = 0;
        model_step(c, ct, g, dt, cx, outcome, amt);
        first_dk = '0; first_cv = '0;
        if (outcome == 1) begin
            first_dk = drinktk_ind;
            for (int k = 0; k < HOLD; k++) begin
                checks++;
                if (obs() !== expv(3, 0, int'(dt))) begin
                    errors++;
                    $display("FAIL %s dispense[%0d]: got %h expected %h", name, k, obs(), expv(3, 0, int'(dt)));
                end
                coin_in = 1'($urandom); coin_type = 2'($urandom); go = 1'($urandom);
                drink_type = 2'($urandom); cancel_flag = 1'($urandom);
                @(negedge clk);
                coin_in = 0; go = 0; cancel_flag = 0;
            end
        end
        if (outcome == 2 || (outcome == 1 && amt > 0)) begin
            first_cv = charge_val;
            for (int k = 0; k < HOLD; k++) begin
                checks++;
                if (obs() !== expv(4, amt, 0)) begin
                    errors++;
                    $display("FAIL %s change[%0d]: got %h expected %h", name, k, obs(), expv(4, amt, 0));
                end
                coin_in = 1'($urandom); coin_type = 2'($urandom); go = 1'($urandom);
                drink_type = 2'($urandom); cancel_flag = 1'($urandom);
                @(negedge clk);
                coin_in = 0; go = 0; cancel_flag = 0;
            end
        end
        checks++;
        if (obs() !== expv(idle_st(), 0, 0)) begin
            errors++;
            $display("FAIL %s settle: got %h expected %h", name, obs(), expv(idle_st(), 0, 0));
        end
    endtask

    task automatic test_reset();
        reset = 1; op_start = 0; coin_in = 0; go = 0; cancel_flag = 0;
        coin_type = 0; drink_type = 0; m_op = 0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (obs() !== expv(0, 0, 0)) begin
            errors++; $display("FAIL reset_state: got %h expected %h", obs(), expv(0, 0, 0));
        end
        reset = 0;
        coin_in = 1; coin_type = 2'b10; go = 1; drink_type = 2'b01;
        @(negedge clk);
        coin_in = 0; go = 0;
        checks++;
        if (obs() !== expv(0, 0, 0)) begin
            errors++; $display("FAIL off_ignores: got %h expected %h", obs(), expv(0, 0, 0));
        end
        op_start = 1; m_op = 1;
        @(negedge clk);
        checks++;
        if (obs() !== expv(1, 0, 0)) begin
            errors++; $display("FAIL power_on: got %h expected %h", obs(), expv(1, 0, 0));
        end
    endtask

    task automatic test_purchase();
        exec_txn("p1_coin", 1, 2'b01, 0, 0, 0);
        exec_txn("p1_coin", 1, 2'b01, 0, 0, 0);
        checks++;
        if (credit !== 5'd10) begin errors++; $display("FAIL p1_credit: got %0d expected 10", credit); end
        exec_txn("p1_buy", 0, 0, 1, 2'b01, 0);
        checks++;
        if (first_dk !== 2'b01) begin errors++; $display("FAIL p1_drink: got %b expected 01", first_dk); end
        checks++;
        if (first_cv !== 5'd7) begin errors++; $display("FAIL p1_change: got %0d expected 7", first_cv); end
        checks++;
        if (num1 !== 5'd9 || credit !== 5'd0 || state !== 3'd1) begin
            errors++; $display("FAIL p1_after: got num1=%0d credit=%0d state=%0d expected 9 0 1", num1, credit, state);
        end
    endtask

    task automatic test_no_money();
        exec_txn("p2_coin", 1, 2'b00, 0, 0, 0);
        exec_txn("p2_coin", 1, 2'b00, 0, 0, 0);
        exec_txn("p2_buy", 0, 0, 1, 2'b10, 0);
        checks++;
        if (no_money !== 1'b1 || credit !== 5'd2 || num2 !== 5'd10) begin
            errors++; $display("FAIL p2_nomoney: got nm=%b credit=%0d num2=%0d expected 1 2 10", no_money, credit, num2);
        end
        exec_txn("p2_cancel", 0, 0, 0, 0, 1);
        checks++;
        if (first_cv !== 5'd2 || state !== 3'd1) begin
            errors++; $display("FAIL p2_refund: got cv=%0d state=%0d expected 2 1", first_cv, state);
        end
    endtask

    task automatic test_overflow();
        exec_txn("p3_coin", 1, 2'b10, 0, 0, 0);
        exec_txn("p3_coin", 1, 2'b10, 0, 0, 0);
        exec_txn("p3_coin", 1, 2'b10, 0, 0, 0);
        exec_txn("p3_coin", 1, 2'b00, 0, 0, 0);
        checks++;
        if (credit !== 5'd31) begin errors++; $display("FAIL p3_full: got %0d expected 31", credit); end
        exec_txn("p3_over", 1, 2'b00, 0, 0, 0);
        checks++;
        if (over_flow !== 1'b1 || credit !== 5'd31) begin
            errors++; $display("FAIL p3_overflow: got of=%b credit=%0d expected 1 31", over_flow, credit);
        end
        exec_txn("p3_invalid", 1, 2'b11, 0, 0, 0);
        exec_txn("p3_cancel", 0, 0, 0, 0, 1);
        checks++;
        if (first_cv !== 5'd31 || over_flow !== 1'b0) begin
            errors++; $display("FAIL p3_refund: got cv=%0d of=%b expected 31 0", first_cv, over_flow);
        end
    endtask

    task automatic test_priority();
        exec_txn("p5_coin", 1, 2'b01, 0, 0, 0);
        exec_txn("p5_all", 1, 2'b01, 1, 2'b01, 1);
        checks++;
        if (first_cv !== 5'd5 || num1 !== 5'd9 || credit !== 5'd0) begin
            errors++; $display("FAIL p5_priority: got cv=%0d num1=%0d credit=%0d expected 5 9 0", first_cv, num1, credit);
        end
    endtask

    task automatic test_stock_empty();
        while (m_stock[1] > 0) begin
            exec_txn("p4_coin", 1, 2'b01, 0, 0, 0);
            exec_txn("p4_buy", 0, 0, 1, 2'b01, 0);
        end
        exec_txn("p4_coin", 1, 2'b01, 0, 0, 0);
        exec_txn("p4_empty", 0, 0, 1, 2'b01, 0);
        checks++;
        if (no_num !== 1'b1 || credit !== 5'd5 || num1 !== 5'd0) begin
            errors++; $display("FAIL p4_nonum: got nn=%b credit=%0d num1=%0d expected 1 5 0", no_num, credit, num1);
        end
        exec_txn("p4_buyb", 0, 0, 1, 2'b10, 0);
        checks++;
        if (first_dk !== 2'b10 || num2 !== 5'd9 || state !== 3'd1) begin
            errors++; $display("FAIL p4_buyb: got dk=%b num2=%0d state=%0d expected 10 9 1", first_dk, num2, state);
        end
    endtask

    task automatic test_random();
        int r;
        bit c, g, cx;
        logic [1:0] ct, dt;
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 99));
            c = 0; g = 0; cx = 0;
            ct = 2'($urandom);
            dt = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'($urandom_range(1, 2));
            if (r < 45) c = 1;
            else if (r < 75) g = 1;
            else if (r < 85) cx = 1;
            else begin c = 1'($urandom); g = 1'($urandom); cx = 1'($urandom); end
            exec_txn("random", c, ct, g, dt, cx);
        end
        if (m_credit > 0) exec_txn("random_flush", 0, 0, 0, 0, 1);
    endtask

    task automatic test_power_off();
        exec_txn("p6_coin", 1, 2'b01, 0, 0, 0);
        exec_txn("p6_coin", 1, 2'b00, 0, 0, 0);
        checks++;
        if (credit !== 5'd6) begin errors++; $display("FAIL p6_credit: got %0d expected 6", credit); end
        m_op = 0;
        exec_txn("p6_off", 0, 0, 0, 0, 0);
        checks++;
        if (first_cv !== 5'd6 || open !== 1'b0 || state !== 3'd0) begin
            errors++; $display("FAIL p6_off: got cv=%0d open=%b state=%0d expected 6 0 0", first_cv, open, state);
        end
    endtask

    task automatic test_reset_mid_dispense();
        reset = 1; model_reset();
        @(negedge clk);
        reset = 0; m_op = 1; op_start = 1;
        @(negedge clk);
        checks++;
        if (obs() !== expv(1, 0, 0)) begin
            errors++; $display("FAIL p6_restart: got %h expected %h", obs(), expv(1, 0, 0));
        end
        exec_txn("p6_coin", 1, 2'b10, 0, 0, 0);
        drink_type = 2'b10; go = 1;
        @(negedge clk);
        go = 0;
        checks++;
        if (can_take !== 1'b1 || num2 !== 5'd9) begin
            errors++; $display("FAIL p6_dispense: got ct=%b num2=%0d expected 1 9", can_take, num2);
        end
        @(negedge clk);
        #2 reset = 1;
        #1;
        model_reset();
        checks++;
        if (obs() !== expv(0, 0, 0)) begin
            errors++; $display("FAIL p6_async_reset: got %h expected %h", obs(), expv(0, 0, 0));
        end
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        test_reset();
        test_purchase();
        test_no_money();
        test_overflow();
        test_priority();
        test_stock_empty();
        test_random();
        test_power_off();
        test_reset_mid_dispense();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vend_txn_ctrl.md
Name: vend_txn_ctrl

Overview:
Transaction sequencer for the two-drink vending machine. It accumulates coin credit and validates each purchase against price and stock. It then sequences the dispense phase followed by the change-return phase. It sits between the debounced panel inputs and the display/indicator logic, and owns the credit register and both stock counters.

Parameters:
PRICE_A, 3, price of drink A (drink_type 01), credit units
PRICE_B, 5, price of drink B (drink_type 10), credit units
STOCK_INIT, 10, stock loaded into num1/num2 at reset (max 31)
HOLD_CYC, 100000000, cycles the dispense and change indications are held (bench uses 4)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears state, reloads stock
op_start  in  1  level; 1 = machine powered on
coin_in  in  1  single-cycle coin strobe
coin_type  in  2  coin value: 00=1, 01=5, 10=10, 11=invalid (ignored)
drink_type  in  2  selection: 01=A, 10=B, 00/11=none
go  in  1  single-cycle purchase strobe
cancel_flag  in  1  single-cycle refund strobe
open  out  1  1 in every state except OFF
credit  out  5  current credit
charge_val  out  5  change being returned; 0 outside CHANGE
charge_ind  out  1  1 in CHANGE
drinktk_ind  out  2  drink being dispensed; 00 outside DISPENSE
can_take  out  1  1 in DISPENSE
no_money  out  1  sticky flag: last go had insufficient credit
no_num  out  1  sticky flag: last go hit empty stock
over_flow  out  1  sticky flag: last coin would exceed 31
num1  out  5  drink A stock
num2  out  5  drink B stock
state  out  3  FSM encoding: OFF=0, IDLE=1, CREDIT=2, DISPENSE=3, CHANGE=4

Behaviour:
- Reset (asynchronous): state=OFF. All outputs are 0 except num1=num2=STOCK_INIT. Hold counter and change register are cleared.
- OFF: op_start=1 moves the FSM to IDLE on the next cycle. All strobes are ignored.
- IDLE (credit=0) and CREDIT (credit>0) handle strobes with one event per cycle. Priority is cancel_flag > go > coin_in; any lower-priority strobe in the same cycle is dropped.
- coin_in with a valid type:
  - If credit+value ≤ 31: credit += value, go to CREDIT, clear all three sticky flags.
  - Otherwise: credit unchanged, over_flow=1.
- coin_type 11 does nothing.
- go with drink_type 00/11 does nothing.
- go with drink_type 01 or 10, checked in this order:
  - Selected stock = 0: no_num=1, stay in the current state.
  - Else credit < price: no_money=1, stay in the current state.
  - Else: change register = credit−price, credit=0, selected stock decrements by 1, drinktk_ind=drink_type, go to DISPENSE. All sticky flags clear.
- cancel_flag:
  - credit>0: change register=credit, credit=0, go to CHANGE, clear the sticky flags.
  - credit=0: no-op.
- op_start=0 in IDLE goes to OFF.
- op_start=0 in CREDIT is treated as a cancel (credit goes to CHANGE), then OFF after CHANGE completes.
- DISPENSE: can_take=1 and drinktk_ind held for exactly HOLD_CYC cycles; all strobes ignored. Then:
  - Change register > 0: go to CHANGE.
  - Else: go to IDLE, or OFF if op_start=0.
- CHANGE: charge_ind=1 and charge_val=change register for exactly HOLD_CYC cycles; all strobes ignored. Then charge_val=0, change register=0, and go to IDLE, or OFF if op_start=0.
- The hold counter resets on entry to DISPENSE/CHANGE. No state latches for more than HOLD_CYC cycles.
- Stock never wraps below 0; it is only reloaded by reset.
- Reset mid-DISPENSE/CHANGE: the transaction is abandoned with no pending change. Stock reloads to STOCK_INIT.
- All outputs are registered, so outputs reflect a strobe one cycle after it is sampled.

Test Plan:
1. Reset, op_start=1, coins 01,01 (credit 10), drink 01 + go → drinktk_ind=01 and can_take for 4 cycles, num1=9; then charge_ind with charge_val=7 for 4 cycles; then IDLE, credit=0.
2. Coins 00,00 (credit 2), drink 10 + go → no_money=1, credit stays 2, num2=10; cancel → charge_val=2 for 4 cycles, then IDLE.
3. Coins 10,10,10,00 → credit 31; another 00 → over_flow=1, credit 31; cancel → charge_val=31, over_flow cleared.
4. STOCK_INIT=1: buy A with credit 3 → num1=0; add coin 01, go A → no_num=1, credit 5, num1 stays 0; buying B still succeeds.
5. Credit 5, cancel+go(drink 01)+coin_in(01) asserted in the same cycle → CHANGE with charge_val=5, num1 unchanged, credit not incremented.
6. Reset asserted mid-DISPENSE → immediate OFF, outputs 0, num1/num2=STOCK_INIT. Separately, op_start=0 in CREDIT with credit 6 → CHANGE with charge_val=6, then OFF with open=0.
